// File: rtl/bw_r_rf_pkg.sv
// Shared definitions for the decoded-wordline register file.
// - ERR_RD / ERR_WR : bit positions inside err_sticky.
// - MAX_WL          : widest wordline the helper function accepts.
// - onehot_idx      : binary index of a one-hot vector. It ORs together the
//                     positions of every set bit, so the result is only
//                     meaningful when exactly one bit is set. Callers qualify
//                     it with zero/multi-hot detection.
package bw_r_rf_pkg;

  localparam int ERR_RD = 0;
  localparam int ERR_WR = 1;
  localparam int MAX_WL = 64;

  function automatic logic [5:0] onehot_idx(input logic [MAX_WL-1:0] vec);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_WL; i++) begin
      if (vec[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bw_r_rf_wl_dec.sv
// Wordline decoder: converts a decoded (one-hot) wordline into a binary
// index and flags the illegal cases.
// Ports:
//   wl       in  [N-1:0]        wordline vector
//   idx      out [$clog2(N)-1:0] index of the set bit (valid only when one-hot)
//   is_zero  out                 no wordline asserted
//   is_multi out                 more than one wordline asserted
module bw_r_rf_wl_dec
  import bw_r_rf_pkg::*;
#(
  parameter int N = 16,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  wl,
  output logic [IW-1:0] idx,
  output logic          is_zero,
  output logic          is_multi
);

  logic [MAX_WL-1:0] wl_ext;

  always_comb begin
    wl_ext        = '0;
    wl_ext[N-1:0] = wl;
  end

  assign idx     = IW'(onehot_idx(wl_ext));
  assign is_zero = ~|wl;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign is_multi = |(wl & (wl - N'(1)));

endmodule

// File: rtl/bw_r_rf_prm_wld.sv
// Parametrised 1R/1W register file with decoded wordlines.
// All requests pass through an input flop stage (_d1); writes commit and
// dout updates one edge after capture.
// Ports:
//   rclk, reset       clock, synchronous active-high reset
//   din, wr_be        write data and byte enables (wr_be ignored when BYTE_EN=0)
//   wr_wl, wr_en      one-hot write wordline and write request
//   rd_wl, read_en    one-hot read wordline and read request
//   rst_tri_en        test gate: blocks writes, forces read data to all ones
//   sehold            freezes the input stage (except rst_tri_en)
//   err_clr           clears err_sticky
//   dout              registered read data
//   vld               per-entry valid bits
//   rd_err, wr_err    one-cycle pulses for illegal read/write wordlines
//   err_sticky        {wr, rd} sticky error flags
module bw_r_rf_prm_wld
  import bw_r_rf_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 128,
  parameter int BYTE_EN = 1,
  parameter int BYPASS  = 0
) (
  input  logic               rclk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   din,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic [DEPTH-1:0]   wr_wl,
  input  logic               wr_en,
  input  logic [DEPTH-1:0]   rd_wl,
  input  logic               read_en,
  input  logic               rst_tri_en,
  input  logic               sehold,
  input  logic               err_clr,
  output logic [WIDTH-1:0]   dout,
  output logic [DEPTH-1:0]   vld,
  output logic               rd_err,
  output logic               wr_err,
  output logic [1:0]         err_sticky
);

  localparam int NB = WIDTH / 8;
  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] din_d1;
  logic [NB-1:0]    wr_be_d1;
  logic [DEPTH-1:0] wr_wl_d1;
  logic [DEPTH-1:0] rd_wl_d1;
  logic             wr_en_d1;
  logic             read_en_d1;
  logic             rst_tri_en_d1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [IW-1:0]    rd_idx, wr_idx;
  logic             rd_zero, rd_multi, wr_zero, wr_multi;
  logic             wr_go, rd_bad, wr_bad, same_idx;
  logic [WIDTH-1:0] byp_data;

  // Input stage. Control flops are reset; data flops only follow sehold.
  always_ff @(posedge rclk) begin
    if (reset) begin
      wr_en_d1   <= 1'b0;
      read_en_d1 <= 1'b0;
    end else if (!sehold) begin
      wr_en_d1   <= wr_en;
      read_en_d1 <= read_en;
    end
  end

  // The test gate must react even while the scan hold is active.
  always_ff @(posedge rclk) begin
    if (reset) rst_tri_en_d1 <= 1'b0;
    else       rst_tri_en_d1 <= rst_tri_en;
  end

  always_ff @(posedge rclk) begin
    if (!sehold) begin
      din_d1   <= din;
      wr_be_d1 <= wr_be;
      wr_wl_d1 <= wr_wl;
      rd_wl_d1 <= rd_wl;
    end
  end

  bw_r_rf_wl_dec #(.N(DEPTH)) u_rd_dec (
    .wl       (rd_wl_d1),
    .idx      (rd_idx),
    .is_zero  (rd_zero),
    .is_multi (rd_multi)
  );

  bw_r_rf_wl_dec #(.N(DEPTH)) u_wr_dec (
    .wl       (wr_wl_d1),
    .idx      (wr_idx),
    .is_zero  (wr_zero),
    .is_multi (wr_multi)
  );

  assign wr_go    = wr_en_d1 & ~rst_tri_en_d1 & ~wr_zero & ~wr_multi;
  assign wr_bad   = wr_en_d1 & ~rst_tri_en_d1 & wr_multi;
  assign rd_bad   = read_en_d1 & ~rst_tri_en_d1 & (rd_zero | rd_multi);
  assign same_idx = wr_go & (wr_idx == rd_idx);

  // Array: contents survive reset; vld hides anything not written since.
  always_ff @(posedge rclk) begin
    if (wr_go) begin
      if (BYTE_EN == 0) begin
        mem[wr_idx] <= din_d1;
      end else begin
        for (int b = 0; b < NB; b++) begin
          if (wr_be_d1[b]) mem[wr_idx][b*8 +: 8] <= din_d1[b*8 +: 8];
        end
      end
    end
  end

  // Value the entry will hold after this edge's write; used for bypass reads.
  always_comb begin
    byp_data = mem[rd_idx];
    if (BYTE_EN == 0) begin
      byp_data = din_d1;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be_d1[b]) byp_data[b*8 +: 8] = din_d1[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      vld <= '0;
    end else if (wr_go) begin
      vld[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      dout   <= '0;
      rd_err <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      rd_err <= rd_bad;
      wr_err <= wr_bad;
      if (read_en_d1) begin
        if (rst_tri_en_d1)                dout <= '1;
        else if (rd_zero || rd_multi)     dout <= '0;
        else if (BYPASS != 0 && same_idx) dout <= byp_data;
        else if (!vld[rd_idx])            dout <= '0;
        else                              dout <= mem[rd_idx];
      end
    end
  end

  // A new error wins over a clear arriving in the same cycle.
  always_ff @(posedge rclk) begin
    if (reset) begin
      err_sticky <= 2'b00;
    end else begin
      err_sticky[ERR_RD] <= rd_bad | (err_sticky[ERR_RD] & ~err_clr);
      err_sticky[ERR_WR] <= wr_bad | (err_sticky[ERR_WR] & ~err_clr);
    end
  end

endmodule

// File: tb/tb_bw_r_rf_prm_wld.sv
// Directed bench for bw_r_rf_prm_wld. Two instances share all inputs:
// dut0 with BYPASS=0 and dut1 with BYPASS=1.
module tb_bw_r_rf_prm_wld;

  logic         clk;
  logic         reset;
  logic [127:0] din;
  logic [15:0]  wr_be;
  logic [15:0]  wr_wl;
  logic         wr_en;
  logic [15:0]  rd_wl;
  logic         read_en;
  logic         rst_tri_en;
  logic         sehold;
  logic         err_clr;

  logic [127:0] dout0, dout1;
  logic [15:0]  vld0, vld1;
  logic         rd_err0, rd_err1, wr_err0, wr_err1;
  logic [1:0]   sticky0, sticky1;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] E3  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] V11 = {16{8'h11}};
  localparam logic [127:0] V22 = {16{8'h22}};
  localparam logic [127:0] VAA = {16{8'hAA}};
  localparam logic [127:0] VBB = {16{8'hBB}};

  bw_r_rf_prm_wld #(.DEPTH(16), .WIDTH(128), .BYTE_EN(1), .BYPASS(0)) dut0 (
    .rclk(clk), .reset(reset), .din(din), .wr_be(wr_be), .wr_wl(wr_wl),
    .wr_en(wr_en), .rd_wl(rd_wl), .read_en(read_en), .rst_tri_en(rst_tri_en),
    .sehold(sehold), .err_clr(err_clr), .dout(dout0), .vld(vld0),
    .rd_err(rd_err0), .wr_err(wr_err0), .err_sticky(sticky0)
  );

  bw_r_rf_prm_wld #(.DEPTH(16), .WIDTH(128), .BYTE_EN(1), .BYPASS(1)) dut1 (
    .rclk(clk), .reset(reset), .din(din), .wr_be(wr_be), .wr_wl(wr_wl),
    .wr_en(wr_en), .rd_wl(rd_wl), .read_en(read_en), .rst_tri_en(rst_tri_en),
    .sehold(sehold), .err_clr(err_clr), .dout(dout1), .vld(vld1),
    .rd_err(rd_err1), .wr_err(wr_err1), .err_sticky(sticky1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] wl, input logic [127:0] data, input logic [15:0] be);
    wr_wl = wl; din = data; wr_be = be; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    $display("txn write wl=%h be=%h din=%h", wl, be, data);
  endtask

  task automatic do_read(input logic [15:0] wl);
    rd_wl = wl; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    tick();
    $display("txn read  wl=%h dout=%h", wl, dout0);
  endtask

  task automatic test_reset();
    reset = 1'b1; din = '0; wr_be = '0; wr_wl = '0; wr_en = 1'b0;
    rd_wl = '0; read_en = 1'b0; rst_tri_en = 1'b0; sehold = 1'b0; err_clr = 1'b0;
    tick(); tick();
    if (dout0 !== 128'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", dout0); end
    total++;
    if (vld0 !== 16'h0) begin bad++; $display("FAIL reset_vld got=%h exp=0", vld0); end
    total++;
    if ({rd_err0, wr_err0, sticky0} !== 4'b0) begin
      bad++; $display("FAIL reset_err got=%b exp=0000", {rd_err0, wr_err0, sticky0});
    end
    total++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    do_write(16'h0008, E3, 16'hFFFF);
    do_read(16'h0008);
    if (dout0 !== E3) begin bad++; $display("FAIL wr_rd_dout got=%h exp=%h", dout0, E3); end
    total++;
    if (vld0 !== 16'h0008) begin bad++; $display("FAIL wr_rd_vld got=%h exp=0008", vld0); end
    total++;
  endtask

  task automatic test_unwritten_and_byte();
    do_read(16'h0020);
    if (dout0 !== 128'h0) begin bad++; $display("FAIL unwritten_dout got=%h exp=0", dout0); end
    total++;
    if (rd_err0 !== 1'b0) begin bad++; $display("FAIL unwritten_rd_err got=%b exp=0", rd_err0); end
    total++;
    do_write(16'h0020, 128'h0, 16'hFFFF);
    do_write(16'h0020, {{15{8'hFF}}, 8'hA5}, 16'h0001);
    do_read(16'h0020);
    if (dout0 !== 128'hA5) begin bad++; $display("FAIL byte_wr_dout got=%h exp=%h", dout0, 128'hA5); end
    total++;
  endtask

  task automatic test_same_cycle();
    do_write(16'h0080, V11, 16'hFFFF);
    wr_wl = 16'h0080; din = V22; wr_be = 16'hFFFF; wr_en = 1'b1;
    rd_wl = 16'h0080; read_en = 1'b1;
    tick();
    wr_en = 1'b0; read_en = 1'b0;
    tick();
    $display("txn rd+wr wl=0080 dout_b0=%h dout_b1=%h", dout0, dout1);
    if (dout0 !== V11) begin bad++; $display("FAIL rdw_nobypass got=%h exp=%h", dout0, V11); end
    total++;
    if (dout1 !== V22) begin bad++; $display("FAIL rdw_bypass got=%h exp=%h", dout1, V22); end
    total++;
    do_read(16'h0080);
    if (dout0 !== V22) begin bad++; $display("FAIL rdw_after got=%h exp=%h", dout0, V22); end
    total++;
  endtask

  task automatic test_multihot_write();
    do_write(16'h0001, VAA, 16'hFFFF);
    do_write(16'h0010, VBB, 16'hFFFF);
    wr_wl = 16'h0011; din = {16{8'hCC}}; wr_be = 16'hFFFF; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    $display("txn write wl=0011 wr_err=%b sticky=%b", wr_err0, sticky0);
    if (wr_err0 !== 1'b1) begin bad++; $display("FAIL multi_wr_err got=%b exp=1", wr_err0); end
    total++;
    if (sticky0 !== 2'b10) begin bad++; $display("FAIL multi_sticky got=%b exp=10", sticky0); end
    total++;
    if (rd_err0 !== 1'b0) begin bad++; $display("FAIL multi_no_rd_err got=%b exp=0", rd_err0); end
    total++;
    tick();
    if (wr_err0 !== 1'b0) begin bad++; $display("FAIL multi_pulse_end got=%b exp=0", wr_err0); end
    total++;
    do_read(16'h0001);
    if (dout0 !== VAA) begin bad++; $display("FAIL multi_e0 got=%h exp=%h", dout0, VAA); end
    total++;
    do_read(16'h0010);
    if (dout0 !== VBB) begin bad++; $display("FAIL multi_e4 got=%h exp=%h", dout0, VBB); end
    total++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    if (sticky0 !== 2'b00) begin bad++; $display("FAIL err_clr got=%b exp=00", sticky0); end
    total++;
  endtask

  task automatic test_bad_read();
    do_read(16'h0000);
    if (rd_err0 !== 1'b1) begin bad++; $display("FAIL zero_rd_err got=%b exp=1", rd_err0); end
    total++;
    if (dout0 !== 128'h0) begin bad++; $display("FAIL zero_rd_dout got=%h exp=0", dout0); end
    total++;
    if (sticky0 !== 2'b01) begin bad++; $display("FAIL zero_rd_sticky got=%b exp=01", sticky0); end
    total++;
    tick();
    if (rd_err0 !== 1'b0) begin bad++; $display("FAIL rd_pulse_end got=%b exp=0", rd_err0); end
    total++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    // Multi-hot read whose error lands in the same cycle as a clear.
    rd_wl = 16'h0003; read_en = 1'b1;
    tick();
    read_en = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    $display("txn read  wl=0003 rd_err=%b sticky=%b", rd_err0, sticky0);
    if (rd_err0 !== 1'b1) begin bad++; $display("FAIL multi_rd_err got=%b exp=1", rd_err0); end
    total++;
    if (sticky0 !== 2'b01) begin bad++; $display("FAIL set_clr_same got=%b exp=01", sticky0); end
    total++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_rst_tri();
    rst_tri_en = 1'b1;
    rd_wl = 16'h0008; read_en = 1'b1;
    wr_wl = 16'h0008; din = 128'h0; wr_be = 16'hFFFF; wr_en = 1'b1;
    tick();
    rst_tri_en = 1'b0; read_en = 1'b0; wr_en = 1'b0;
    tick();
    $display("txn tri   rd/wr wl=0008 dout=%h", dout0);
    if (dout0 !== {128{1'b1}}) begin bad++; $display("FAIL tri_dout got=%h exp=all ones", dout0); end
    total++;
    if ({rd_err0, wr_err0} !== 2'b00) begin
      bad++; $display("FAIL tri_no_err got=%b exp=00", {rd_err0, wr_err0});
    end
    total++;
    do_read(16'h0008);
    if (dout0 !== E3) begin bad++; $display("FAIL tri_array got=%h exp=%h", dout0, E3); end
    total++;
  endtask

  task automatic test_sehold();
    do_read(16'h0080);
    rd_wl = 16'h0008; read_en = 1'b1;
    tick();
    sehold = 1'b1; rd_wl = 16'h0080;
    tick();
    if (dout0 !== E3) begin bad++; $display("FAIL sehold_1 got=%h exp=%h", dout0, E3); end
    total++;
    rd_wl = 16'h0001;
    tick();
    $display("txn hold  rd_wl=0001 dout=%h", dout0);
    if (dout0 !== E3) begin bad++; $display("FAIL sehold_2 got=%h exp=%h", dout0, E3); end
    total++;
    reset = 1'b1;
    tick();
    if (dout0 !== 128'h0) begin bad++; $display("FAIL hold_reset_dout got=%h exp=0", dout0); end
    total++;
    if (vld0 !== 16'h0) begin bad++; $display("FAIL hold_reset_vld got=%h exp=0", vld0); end
    total++;
    reset = 1'b0; sehold = 1'b0; read_en = 1'b0;
    tick();
    // Entry 3 still holds data in the array but is no longer valid.
    do_read(16'h0008);
    if (dout0 !== 128'h0) begin bad++; $display("FAIL stale_hidden got=%h exp=0", dout0); end
    total++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_unwritten_and_byte();
    test_same_cycle();
    test_multihot_write();
    test_bad_read();
    test_rst_tri();
    test_sehold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bw_r_rf_prm_wld.md
Name: bw_r_rf_prm_wld

Overview:
- Parametrised 1R/1W register file macro model; DEPTH entries x WIDTH bits, addressed by decoded (one-hot) wordlines.
- Next generation of the fixed 16x128 decoded-wordline RF used in the core queues (IFQ/LSU/FPU buffers).
- Adds the following over the fixed macro: configurable geometry, byte-granular writes, selectable read-during-write bypass, per-entry valid bits, and sticky wordline error status.
- All behaviour is synchronous; no X generation, so the model is synthesizable and usable in FPGA builds.

Parameters:
- DEPTH, 16: number of entries; one wordline bit per entry; 2..64.
- WIDTH, 128: data width in bits; must be a multiple of 8 when BYTE_EN=1.
- BYTE_EN, 1: 1 = wr_be qualifies each byte; 0 = wr_be ignored and full-word writes only.
- BYPASS, 0: 0 = read of the entry being written returns old data; 1 = returns merged new data.

Ports:
- rclk, input, 1: clock. Single clock; all state updates on posedge rclk.
- reset, input, 1: synchronous reset, active-high.
- din, input, WIDTH: write data.
- wr_be, input, WIDTH/8: byte write enables; bit k covers din[8k+7:8k].
- wr_wl, input, DEPTH: one-hot write wordline.
- wr_en, input, 1: write request.
- rd_wl, input, DEPTH: one-hot read wordline.
- read_en, input, 1: read request.
- rst_tri_en, input, 1: scan/test gate. Blocks writes; forces read data to all ones.
- sehold, input, 1: holds the input-stage flops.
- err_clr, input, 1: clears the sticky error status.
- dout, output, WIDTH: registered read data.
- vld, output, DEPTH: per-entry valid bits.
- rd_err, output, 1: one-cycle pulse, bad read wordline.
- wr_err, output, 1: one-cycle pulse, bad write wordline.
- err_sticky, output, 2: {wr, rd} sticky error flags.

Behaviour:
- Input stage (_d1 flops): din, wr_be, wr_wl, wr_en, rd_wl, read_en, rst_tri_en.
  - Captured at posedge N.
  - Hold their value while sehold=1, except rst_tri_en_d1, which always samples.
- Priority: reset > sehold.
- Reset (sync, while reset=1) clears:
  - wr_en_d1, read_en_d1, rst_tri_en_d1;
  - dout=0, vld=0, rd_err=0, wr_err=0, err_sticky=0.
  - Array contents are not cleared.
- Latency: request at edge N; write commit and dout update at edge N+1. Read-to-dout latency is 1 cycle after capture.
- Write at edge N+1, when wr_en_d1=1 and rst_tri_en_d1=0:
  - wr_wl_d1 one-hot: bytes with be=1 are updated; vld[idx] is set.
  - wr_wl_d1 all-zero: no-op, no error.
  - wr_wl_d1 multi-hot: no write, wr_err=1 for one cycle.
- Write with rst_tri_en_d1=1: no write and no error.
- Read at edge N+1, when read_en_d1=1:
  - rst_tri_en_d1=1: dout = all ones.
  - rd_wl_d1 zero or multi-hot: dout=0, rd_err=1 for one cycle.
  - vld[idx]=0: dout=0 (stale array data is never exposed after reset).
  - Otherwise dout = entry[idx].
- Read with read_en_d1=0: dout holds its previous value.
- Same-index read and write in the same cycle:
  - BYPASS=0: dout = pre-write contents.
  - BYPASS=1: dout = byte merge of wr_be_d1 ? din_d1 : old contents; vld is treated as 1.
- Sticky status:
  - err_sticky[0] set by rd_err; err_sticky[1] set by wr_err.
  - err_clr=1 clears both.
  - A set and a clear in the same cycle leaves the bit set.
- Non-read cycles never pulse rd_err. Non-write cycles never pulse wr_err.

Decomposition:
- Package bw_r_rf_pkg:
  - function onehot_idx(vector) -> index;
  - error-bit position constants ERR_RD=0, ERR_WR=1.
- Sub-module bw_r_rf_wl_dec:
  - parameter N;
  - input wl[N-1:0];
  - outputs idx, is_zero, is_multi.
  - Instantiated twice, once for the read wordline and once for the write wordline.

Test Plan:
- Reset, then write entry 3 = 0x0123..EF with all be=1, then read wl=0x0008 -> dout=0x0123..EF two cycles after the read request; vld=0x0008.
- After reset, read entry 5 (never written) -> dout=0, rd_err=0. Write entry 5 with wr_be=0x0001 and din LSB=0xA5, then read -> dout=0x00..A5.
- Read and write entry 7 in the same cycle (old value 0x11.., new value 0x22..) -> dout=0x11.. when BYPASS=0; dout=0x22.. when BYPASS=1.
- Write with wr_wl=0x0011 -> wr_err pulses for 1 cycle, entries 0 and 4 unchanged, err_sticky=2'b10. Then err_clr -> err_sticky=0.
- rst_tri_en=1 with read_en=1 and wr_en=1 -> dout all ones, array unchanged, no error pulses.
- sehold=1 across a changing rd_wl -> dout keeps re-reading the held index. Assert reset with sehold=1 -> dout=0 and vld=0.
